// File: rtl/alu_op_decoder_pkg.sv
// alu_op_decoder_pkg
// Shared constants for the instruction-to-ALU-control stage and anything
// else that needs to talk about ALU control codes or RV32I fields:
//   - the eleven 4-bit ALU control codes
//   - RV32I major opcodes, funct3 and funct7 values
//   - the immediate format selector used by the immediate generator
//   - a helper mapping an arithmetic funct3 to its default ALU code
package alu_op_decoder_pkg;

  // ALU control codes driven toward the ALU
  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SLL    = 4'b0011;
  localparam logic [3:0] ALU_SLT    = 4'b0100;
  localparam logic [3:0] ALU_SLTU   = 4'b0101;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_XOR    = 4'b0111;
  localparam logic [3:0] ALU_SRL    = 4'b1000;
  localparam logic [3:0] ALU_PASS_B = 4'b1001;
  localparam logic [3:0] ALU_SRA    = 4'b1010;

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Arithmetic funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3 values
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 values: base encoding and the SUB/SRA alternate
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Immediate format selector; IMM_NONE produces zero
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Default ALU code for an arithmetic funct3, assuming the base funct7
  // (so 000 is ADD and 101 is SRL); callers patch in SUB/SRA themselves.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      F3_ADD_SUB: code = ALU_ADD;
      F3_SLL:     code = ALU_SLL;
      F3_SLT:     code = ALU_SLT;
      F3_SLTU:    code = ALU_SLTU;
      F3_XOR:     code = ALU_XOR;
      F3_SR:      code = ALU_SRL;
      F3_OR:      code = ALU_OR;
      default:    code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_op_decoder_imm_gen.sv
// alu_op_decoder_imm_gen
// Purely combinational immediate generator for RV32I. Kept separate so the
// PC/branch-target logic can reuse it.
// Ports:
//   instr - instruction bits [31:7]; the opcode field never feeds an immediate
//   fmt   - which immediate format to extract (IMM_NONE gives zero)
//   imm   - sign-extended immediate, Width bits
module alu_op_decoder_imm_gen
  import alu_op_decoder_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic [31:7]      instr,
  input  imm_fmt_e         fmt,
  output logic [Width-1:0] imm
);

  logic [31:0] imm32;

  // Every format sign-extends from instr[31]; B and J force bit 0 low and
  // U places the upper 20 bits with zeros below.
  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = Width'(imm32);

endmodule

// File: rtl/alu_op_decoder.sv
// alu_op_decoder
// Registered RV32I instruction-to-ALU-control stage with a valid/ready
// handshake on both sides. Decoded control appears one cycle after a
// transfer and is held stable while the consumer stalls.
// Ports:
//   clk, reset          - clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   - instruction handshake; in_ready is combinational
//   instr               - RV32I instruction word
//   out_valid/out_ready - decoded-result handshake
//   controlsignal       - 4-bit ALU control code
//   alu_src_imm         - 1 selects imm as operand B, 0 selects rs2
//   imm                 - sign-extended immediate
//   is_branch           - conditional branch, taken test uses ALU zero
//   branch_inv          - 1: taken when zero==1; 0: taken when zero==0
//   illegal             - current output is an unsupported encoding
//   trap                - sticky illegal flag (tied low if ILLEGAL_TRAP=0)
module alu_op_decoder
  import alu_op_decoder_pkg::*;
#(
  parameter int Width        = 32,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       controlsignal,
  output logic             alu_src_imm,
  output logic [Width-1:0] imm,
  output logic             is_branch,
  output logic             branch_inv,
  output logic             illegal,
  output logic             trap
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [3:0]       dec_ctrl;
  logic             dec_src_imm;
  imm_fmt_e         dec_fmt;
  logic             dec_branch;
  logic             dec_inv;
  logic             dec_illegal;
  logic [Width-1:0] dec_imm;
  logic             take;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // A new word can enter whenever the output register is empty or is being
  // consumed this cycle.
  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;

  // Field decode. R-type words carry no immediate, so they select IMM_NONE
  // and present zero. Any illegal encoding collapses to the neutral ADD/rs2
  // setting at the end so downstream never sees half-decoded control.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_src_imm = 1'b0;
    dec_fmt     = IMM_NONE;
    dec_branch  = 1'b0;
    dec_inv     = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_REG: begin
        dec_ctrl = alu_from_funct3(funct3);
        if (funct3 == F3_ADD_SUB || funct3 == F3_SR) begin
          if (funct7 == F7_ALT) begin
            dec_ctrl = (funct3 == F3_SR) ? ALU_SRA : ALU_SUB;
          end else if (funct7 != F7_BASE) begin
            dec_illegal = 1'b1;
          end
        end else if (funct7 != F7_BASE) begin
          dec_illegal = 1'b1;
        end
      end
      OP_IMM: begin
        dec_ctrl    = alu_from_funct3(funct3);
        dec_src_imm = 1'b1;
        dec_fmt     = IMM_I;
        if (funct3 == F3_SLL && funct7 != F7_BASE) begin
          dec_illegal = 1'b1;
        end else if (funct3 == F3_SR) begin
          if (funct7 == F7_ALT) begin
            dec_ctrl = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            dec_illegal = 1'b1;
          end
        end
      end
      OP_LOAD, OP_JALR: begin
        dec_src_imm = 1'b1;
        dec_fmt     = IMM_I;
      end
      OP_STORE: begin
        dec_src_imm = 1'b1;
        dec_fmt     = IMM_S;
      end
      OP_AUIPC: begin
        dec_src_imm = 1'b1;
        dec_fmt     = IMM_U;
      end
      OP_LUI: begin
        dec_ctrl    = ALU_PASS_B;
        dec_src_imm = 1'b1;
        dec_fmt     = IMM_U;
      end
      OP_JAL: begin
        dec_src_imm = 1'b1;
        dec_fmt     = IMM_J;
      end
      OP_BRANCH: begin
        // SLT/SLTU give 1 when less, so "less" means zero==0.
        dec_branch = 1'b1;
        dec_fmt    = IMM_B;
        case (funct3)
          F3_BEQ:  begin dec_ctrl = ALU_SUB;  dec_inv = 1'b1; end
          F3_BNE:  begin dec_ctrl = ALU_SUB;  dec_inv = 1'b0; end
          F3_BLT:  begin dec_ctrl = ALU_SLT;  dec_inv = 1'b0; end
          F3_BGE:  begin dec_ctrl = ALU_SLT;  dec_inv = 1'b1; end
          F3_BLTU: begin dec_ctrl = ALU_SLTU; dec_inv = 1'b0; end
          F3_BGEU: begin dec_ctrl = ALU_SLTU; dec_inv = 1'b1; end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_ctrl    = ALU_ADD;
      dec_src_imm = 1'b0;
      dec_fmt     = IMM_NONE;
      dec_branch  = 1'b0;
      dec_inv     = 1'b0;
    end
  end

  alu_op_decoder_imm_gen #(
    .Width(Width)
  ) u_imm_gen (
    .instr(instr[31:7]),
    .fmt  (dec_fmt),
    .imm  (dec_imm)
  );

  // Output register. While stalled (in_ready low) nothing changes. When the
  // consumer drains without a new word, only out_valid drops; the data
  // fields keep their last values. trap latches on the capture of an
  // illegal word and only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      controlsignal <= ALU_ADD;
      alu_src_imm   <= 1'b0;
      imm           <= '0;
      is_branch     <= 1'b0;
      branch_inv    <= 1'b0;
      illegal       <= 1'b0;
      trap          <= 1'b0;
    end else begin
      if (in_ready) begin
        out_valid <= in_valid;
      end
      if (take) begin
        controlsignal <= dec_ctrl;
        alu_src_imm   <= dec_src_imm;
        imm           <= dec_imm;
        is_branch     <= dec_branch;
        branch_inv    <= dec_inv;
        illegal       <= dec_illegal;
        if (ILLEGAL_TRAP && dec_illegal) begin
          trap <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder
// Directed-vector bench with a scoreboard: each accepted instruction pushes
// its hand-computed decode into a queue, and an independent monitor compares
// the DUT outputs against the queue head whenever out_valid is high, popping
// only when the result is consumed.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  controlsignal;
  logic        alu_src_imm;
  logic [31:0] imm;
  logic        is_branch;
  logic        branch_inv;
  logic        illegal;
  logic        trap;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic        src;
    logic [31:0] imm;
    logic        br;
    logic        inv;
    logic        ill;
    logic        trap;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  act;
  int    checks = 0;
  int    errors = 0;
  logic  exp_trap = 1'b0;

  alu_op_decoder #(
    .Width       (32),
    .ILLEGAL_TRAP(1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .controlsignal(controlsignal),
    .alu_src_imm  (alu_src_imm),
    .imm          (imm),
    .is_branch    (is_branch),
    .branch_inv   (branch_inv),
    .illegal      (illegal),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Present one word and wait until it is accepted; the expectation is
  // queued at the acceptance point so queue order equals transfer order.
  task automatic applyStimulus(input string name, input logic [31:0] word,
                               input logic [3:0] ctrl, input logic src,
                               input logic [31:0] immv, input logic br,
                               input logic inv, input logic ill);
    exp_t e;
    bit   accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    instr    = word;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        if (ill) exp_trap = 1'b1;
        e.ctrl = ctrl;
        e.src  = src;
        e.imm  = immv;
        e.br   = br;
        e.inv  = inv;
        e.ill  = ill;
        e.trap = exp_trap;
        exp_q.push_back(e);
        name_q.push_back(name);
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) checkOutput({name, "_accept_timeout"}, 64'(accepted), 64'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare the head of the scoreboard every cycle the output is
  // valid (so held outputs are re-checked), pop when consumed.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          act = {controlsignal, alu_src_imm, imm, is_branch, branch_inv, illegal, trap};
          checkOutput(name_q[0], 64'(act), 64'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with a valid word pending: nothing may be captured
    reset     = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'h00B50533;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_ctrl", 64'(controlsignal), 64'h2);
    checkOutput("reset_trap", 64'(trap), 64'd0);
    checkOutput("reset_imm", 64'(imm), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b0;

    // Back-to-back legal sweep
    applyStimulus("sub",   32'h40B50533, 4'b0110, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    applyStimulus("and",   32'h00B57533, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    applyStimulus("sra",   32'h40B55533, 4'b1010, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    applyStimulus("srl",   32'h00B55533, 4'b1000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    applyStimulus("sll",   32'h00B51533, 4'b0011, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    applyStimulus("slt",   32'h00B52533, 4'b0100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    applyStimulus("sltu",  32'h00B53533, 4'b0101, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    applyStimulus("or",    32'h00B56533, 4'b0001, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    applyStimulus("addi",  32'hFFF50513, 4'b0010, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus("slli",  32'h00351513, 4'b0011, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0);
    applyStimulus("srai",  32'h40355513, 4'b1010, 1'b1, 32'h00000403, 1'b0, 1'b0, 1'b0);
    applyStimulus("lui",   32'h123452B7, 4'b1001, 1'b1, 32'h12345000, 1'b0, 1'b0, 1'b0);
    applyStimulus("auipc", 32'h00001517, 4'b0010, 1'b1, 32'h00001000, 1'b0, 1'b0, 1'b0);
    applyStimulus("lw",    32'hFF85A503, 4'b0010, 1'b1, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0);
    applyStimulus("sw",    32'h00B52223, 4'b0010, 1'b1, 32'h00000004, 1'b0, 1'b0, 1'b0);
    applyStimulus("sw_neg",32'hFEB52E23, 4'b0010, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0);
    applyStimulus("jalr",  32'h000080E7, 4'b0010, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0);
    applyStimulus("jal",   32'hFFFFF0EF, 4'b0010, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    applyStimulus("beq",   32'h00B50463, 4'b0110, 1'b0, 32'h00000008, 1'b1, 1'b1, 1'b0);
    applyStimulus("bne",   32'h00B51463, 4'b0110, 1'b0, 32'h00000008, 1'b1, 1'b0, 1'b0);
    applyStimulus("blt",   32'h00B54463, 4'b0100, 1'b0, 32'h00000008, 1'b1, 1'b0, 1'b0);
    applyStimulus("bgeu",  32'h00B57463, 4'b0101, 1'b0, 32'h00000008, 1'b1, 1'b1, 1'b0);
    drain();

    // Back-pressure: consumer stalls for three cycles after the first word
    out_ready = 1'b1;
    fork
      begin
        applyStimulus("bp_xor", 32'h00B54533, 4'b0111, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
        applyStimulus("bp_lui", 32'h123452B7, 4'b1001, 1'b1, 32'h12345000, 1'b0, 1'b0, 1'b0);
        applyStimulus("bp_bne", 32'h00B51463, 4'b0110, 1'b0, 32'h00000008, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Illegal encodings set illegal and sticky trap; a later legal add
    // clears illegal only
    applyStimulus("ill_funct7", 32'h02B50533, 4'b0010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus("ill_ones",   32'hFFFFFFFF, 4'b0010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus("add_after",  32'h00B50533, 4'b0010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus("ill_branch", 32'h00B52463, 4'b0010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus("ill_slli",   32'h02351513, 4'b0010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset while an illegal result is held: output discarded, trap cleared
    out_ready = 1'b0;
    applyStimulus("held_ill", 32'hFFFFFFFF, 4'b0010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst2_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst2_trap", 64'(trap), 64'd0);
    checkOutput("rst2_illegal", 64'(illegal), 64'd0);
    checkOutput("rst2_ctrl", 64'(controlsignal), 64'h2);
    exp_q.delete();
    name_q.delete();
    exp_trap  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus("addi_post", 32'hFFF50513, 4'b0010, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    drain();
    repeat (2) @(posedge clk);
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Registered instruction-to-ALU-control stage that drives the 4-bit ALU control code, the operand-B select and the sign-extended immediate toward the ALU.
- Accepts RV32I instruction words under a valid/ready handshake and presents decoded control one cycle later.
- Holds its output under back-pressure, so it fits a single-cycle datapath (downstream always ready) or a pipelined/multi-cycle execute stage.
- Also flags branch type and illegal encodings.

Parameters:
- Width, 32, immediate/data width; must be 32 for RV32I.
- ILLEGAL_TRAP, 1, when 1 an illegal instruction also asserts sticky trap output until reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  RV32I instruction word.
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  consumer accepts decoded fields.
- controlsignal  out  4  ALU control code.
- alu_src_imm  out  1  1: operand B = imm; 0: rs2 data.
- imm  out  Width  sign-extended immediate (I/S/B/U/J format).
- is_branch  out  1  conditional branch; taken test uses ALU zero.
- branch_inv  out  1  taken when zero==1 (BEQ, BGE, BGEU) vs zero==0 (BNE, BLT, BLTU); see Behaviour.
- illegal  out  1  current output is an unsupported encoding.
- trap  out  1  sticky illegal flag (only if ILLEGAL_TRAP=1, else tied 0).

Behaviour:
- Control codes, fixed: AND 0000, OR 0001, ADD 0010, SLL 0011, SLT 0100, SLTU 0101, SUB 0110, XOR 0111, SRL 1000, PASS_B 1001, SRA 1010. No other code is ever emitted.
- Reset (synchronous, takes priority over everything):
  - out_valid=0, controlsignal=0010, alu_src_imm=0, imm=0, is_branch=0, branch_inv=0, illegal=0, trap=0.
  - An in-flight held output is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer occurs when in_valid && in_ready; the decoded result is registered and out_valid=1 the next cycle.
  - Latency is exactly 1 cycle; throughput is 1 per cycle when out_ready=1.
  - If out_valid && !out_ready, all outputs hold stable and no new instr is captured.
  - If out_ready=1 and in_valid=0, out_valid drops to 0 next cycle.
- R-type (opcode 0110011):
  - funct3 000: funct7 0000000 -> ADD; 0100000 -> SUB.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
  - 101: funct7 0000000 -> SRL; 0100000 -> SRA.
  - 110 OR; 111 AND.
  - Any other funct7 -> illegal.
  - alu_src_imm=0.
- I-ALU (0010011): same mapping as R-type except:
  - No SUB; funct3 000 -> ADD regardless of imm.
  - funct3 001 requires instr[31:25]=0000000.
  - funct3 101 requires instr[31:25]=0000000 (SRL) or 0100000 (SRA); otherwise illegal.
  - alu_src_imm=1; imm = I-format.
- Address and link instructions: LOAD (0000011), JALR (1100111) -> ADD, imm I-format, alu_src_imm=1.
- STORE (0100011): ADD, imm S-format, alu_src_imm=1.
- AUIPC (0010111): ADD, imm U-format, alu_src_imm=1.
- LUI (0110111): PASS_B, imm U-format, alu_src_imm=1.
- JAL (1101111): ADD, imm J-format, alu_src_imm=1.
- BRANCH (1100011): is_branch=1, alu_src_imm=0, imm B-format.
  - 000 BEQ -> SUB, branch_inv=1.
  - 001 BNE -> SUB, branch_inv=0.
  - 100 BLT -> SLT, branch_inv=0.
  - 101 BGE -> SLT, branch_inv=1.
  - 110 BLTU -> SLTU, branch_inv=0.
  - 111 BGEU -> SLTU, branch_inv=1.
  - For SLT/SLTU the result is 1 when less, so zero==0 means less.
  - 010/011 -> illegal.
- Unknown opcode or illegal field:
  - illegal=1, controlsignal=0010, alu_src_imm=0, imm=0, is_branch=0, branch_inv=0.
  - trap sets on the capture cycle and stays set until reset.
- Immediates:
  - All formats sign-extend from instr[31].
  - B and J formats have bit0=0.
  - U format places instr[31:12] in [31:12] with zeros below.

Decomposition:
- Shared package: ALU control code constants (the 11 codes above), opcode constants, funct3/funct7 constants.
- Sub-module imm_gen (combinational, instr -> imm by format) is reused later by the PC/branch target logic.
- Decode logic plus the handshake register stay in alu_op_decoder.

Test Plan:
- Reset: reset=1 for 2 cycles with in_valid=1 -> out_valid=0, controlsignal=0010, trap=0.
- R-type sweep: instr 0x40B50533 (sub) -> controlsignal=0110, alu_src_imm=0. Instr 0x00B57533 (and) -> 0000. Instr 0x40B55533 (sra) -> 1010. Each appears one cycle after transfer.
- Immediate and U-type: instr 0xFFF50513 (addi -1) -> 0010, alu_src_imm=1, imm=0xFFFFFFFF. Instr 0x123452B7 (lui) -> 1001, imm=0x12345000.
- Branch: instr 0x00B50463 (beq +8) -> 0110, is_branch=1, branch_inv=1, imm=8. Instr 0x00B57463 (bgeu) -> 0101, branch_inv=1.
- Back-pressure: stream 3 instrs with out_ready low for cycles 2-4 -> in_ready=0 during the hold, outputs stable, no instr lost or duplicated, order preserved.
- Illegal: instr 0x02B50533 (funct7=0000001), then 0xFFFFFFFF -> illegal=1, controlsignal=0010, trap=1 and sticky. A subsequent valid add clears illegal but not trap. Reset clears trap.
